// File: rtl/bit_serializer.sv
// Parallel-in, serial-out bit source: takes a WIDTH-bit word on a ready/load
// handshake and streams it one bit per clock on x_out, MSB or LSB first.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;

    // ready is itself registered, so it alone gates acceptance
    assign accept = load && ready;

    // x_out holds the bit currently on the wire; shreg holds the bits still to come
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            x_out   <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else if (accept) begin
            state   <= SHIFT;
            cnt     <= CW'(WIDTH - 1);
            x_valid <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            ready   <= 1'b0;
            if (MSB_FIRST != 0) begin
                x_out <= data_in[WIDTH-1];
                shreg <= data_in << 1;
            end else begin
                x_out <= data_in[0];
                shreg <= data_in >> 1;
            end
        end else if (state == SHIFT && cnt != '0) begin
            cnt   <= cnt - CW'(1);
            done  <= (cnt == CW'(1));
            ready <= (cnt == CW'(1));
            if (MSB_FIRST != 0) begin
                x_out <= shreg[WIDTH-1];
                shreg <= shreg << 1;
            end else begin
                x_out <= shreg[0];
                shreg <= shreg >> 1;
            end
        end else if (state == SHIFT) begin
            // last bit has been shown and no follow-on word arrived
            state   <= IDLE;
            shreg   <= '0;
            x_out   <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer: an 8-bit MSB-first instance
// and a 4-bit LSB-first instance, checked as {x_out,x_valid,busy,done,ready}.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data8;
    logic       load8;
    logic       ready8, x8, valid8, busy8, done8;
    logic [3:0] data4;
    logic       load4;
    logic       ready4, x4, valid4, busy4, done4;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] IDLE_OUT = 5'b00001;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut8 (
        .clk(clk), .reset(reset), .data_in(data8), .load(load8),
        .ready(ready8), .x_out(x8), .x_valid(valid8), .busy(busy8), .done(done8)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut4 (
        .clk(clk), .reset(reset), .data_in(data4), .load(load4),
        .ready(ready4), .x_out(x4), .x_valid(valid4), .busy(busy4), .done(done4)
    );

    function automatic logic [4:0] obs8();
        return {x8, valid8, busy8, done8, ready8};
    endfunction

    function automatic logic [4:0] obs4();
        return {x4, valid4, busy4, done4, ready4};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        load8 = 1'b0;
        load4 = 1'b0;
        data8 = '0;
        data4 = '0;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (obs8() !== IDLE_OUT) begin
                errors++;
                $display("FAIL reset8 cycle %0d: got %b expected %b", k, obs8(), IDLE_OUT);
            end
            checks++;
            if (obs4() !== IDLE_OUT) begin
                errors++;
                $display("FAIL reset4 cycle %0d: got %b expected %b", k, obs4(), IDLE_OUT);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] word = 8'hAA;
        logic [4:0] exp;
        data8 = word;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        data8 = '0;
        for (int k = 1; k <= 8; k++) begin
            exp = {word[8-k], 1'b1, 1'b1, k == 8, k == 8};
            checks++;
            if (obs8() !== exp) begin
                errors++;
                $display("FAIL single cycle %0d: got %b expected %b", k, obs8(), exp);
            end
            @(negedge clk);
        end
        checks++;
        if (obs8() !== IDLE_OUT) begin
            errors++;
            $display("FAIL single_idle: got %b expected %b", obs8(), IDLE_OUT);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = 16'hAA0F;
        logic [4:0]  exp;
        data8 = 8'hAA;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            exp = {stream[16-k], 1'b1, 1'b1, (k == 8) || (k == 16), (k == 8) || (k == 16)};
            checks++;
            if (obs8() !== exp) begin
                errors++;
                $display("FAIL b2b cycle %0d: got %b expected %b", k, obs8(), exp);
            end
            if (k == 8) begin
                load8 = 1'b1;
                data8 = 8'h0F;
            end else begin
                load8 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (obs8() !== IDLE_OUT) begin
            errors++;
            $display("FAIL b2b_idle: got %b expected %b", obs8(), IDLE_OUT);
        end
    endtask

    task automatic test_ignored_load();
        logic [7:0] word = 8'h3C;
        logic [4:0] exp;
        data8 = word;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp = {word[8-k], 1'b1, 1'b1, k == 8, k == 8};
            checks++;
            if (obs8() !== exp) begin
                errors++;
                $display("FAIL ignored cycle %0d: got %b expected %b", k, obs8(), exp);
            end
            if (k == 3) begin
                load8 = 1'b1;
                data8 = 8'hFF;
            end else begin
                load8 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (obs8() !== IDLE_OUT) begin
            errors++;
            $display("FAIL ignored_idle: got %b expected %b", obs8(), IDLE_OUT);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] word = 8'hAA;
        logic [7:0] next_word = 8'h81;
        logic [4:0] exp;
        data8 = word;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = {word[8-k], 1'b1, 1'b1, 1'b0, 1'b0};
            checks++;
            if (obs8() !== exp) begin
                errors++;
                $display("FAIL midreset_pre cycle %0d: got %b expected %b", k, obs8(), exp);
            end
            if (k < 4) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs8() !== IDLE_OUT) begin
                errors++;
                $display("FAIL midreset_idle %0d: got %b expected %b", k, obs8(), IDLE_OUT);
            end
            @(negedge clk);
        end
        data8 = next_word;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp = {next_word[8-k], 1'b1, 1'b1, k == 8, k == 8};
            checks++;
            if (obs8() !== exp) begin
                errors++;
                $display("FAIL midreset_reload cycle %0d: got %b expected %b", k, obs8(), exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] word = 4'b0101;
        logic [4:0] exp;
        data4 = word;
        load4 = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp = {word[k-1], 1'b1, 1'b1, k == 4, k == 4};
            checks++;
            if (obs4() !== exp) begin
                errors++;
                $display("FAIL lsb cycle %0d: got %b expected %b", k, obs4(), exp);
            end
            @(negedge clk);
        end
        checks++;
        if (obs4() !== IDLE_OUT) begin
            errors++;
            $display("FAIL lsb_idle: got %b expected %b", obs4(), IDLE_OUT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_word();
        test_lsb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
